if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
// - Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
// - Owns the program counter and drives the synchronous instruction-memory address.
// - Presents pc_if to IF/ID; a memory read issued with pc_if returns in ID one cycle later, aligned with pc_id.
// - Handles boot hold, stall, branch/jump redirect and wrong-path kill signalling.
// PARAMETERS
// - DATA_SIZE    32  instruction width, bits
// - ADDR_SIZE    10  word-address width of instruction memory; PC is ADDR_SIZE+2 bits (byte address)
// - RESET_PC     0   byte address loaded into PC on reset
// - BOOT_CYCLES  2   cycles held in BOOT after reset release (memory settle), >=1
// PORTS
// - clk            in   1              rising-edge clock
// - rst_n          in   1              asynchronous active-low reset
// - enable         in   1              1 = advance; 0 = stall (hazard unit); same net as IF/ID enable
// - redirect_valid in   1              taken branch/jump resolved this cycle
// - redirect_pc    in   ADDR_SIZE+2    redirect target byte address
// - pc_if          out  ADDR_SIZE+2    current fetch PC, to IF/ID pc_if
// - imem_addr      out  ADDR_SIZE      word address to synchronous instruction memory
// - imem_en        out  1              memory read enable; low = memory holds last output
// - fetch_valid    out  1              pc_if is a real fetch (0 during BOOT)
// - kill_id        out  1              instruction now in ID is wrong-path; ID must issue NOP
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - pc_if=RESET_PC, state=BOOT, boot counter=0, kill_id=0, fetch_valid=0.
//   - imem_en=0, imem_addr=RESET_PC[ADDR_SIZE+1:2].
// - imem_addr = pc_if[ADDR_SIZE+1:2], combinational; redirect_pc[1:0] ignored (target forced word-aligned).
// - States:
//   - BOOT: PC held, imem_en=0, fetch_valid=0.
//     - Counter increments each cycle; at BOOT_CYCLES-1 -> RUN.
//     - redirect/enable ignored in BOOT.
//   - RUN: imem_en=enable, fetch_valid=1.
//     - enable=1: pc_if <= pc_if+4.
//     - enable=0 -> STALL with PC held.
//   - STALL: PC and memory held, imem_en=0, fetch_valid=1.
//     - enable=1 -> RUN and PC advances that same edge.
// - Redirect (RUN or STALL), priority over stall:
//   - pc_if <= {redirect_pc[ADDR_SIZE+1:2],2'b00} and imem_en=1 regardless of enable.
//   - Next state RUN.
//   - kill_id=1 for exactly the following cycle.
// - kill_id is registered:
//   - 1-cycle pulse per redirect.
//   - Back-to-back redirects produce back-to-back pulses; the last target wins.
// - PC arithmetic modulo 2^(ADDR_SIZE+2): max word address +4 wraps to 0, no flag.
// - Redirect target equal to current pc_if is legal: PC reloads and kill_id still pulses.
// - Reset asserted mid-operation: immediate return to reset values (async); BOOT restarts on release.
// - Latency: redirect accepted at edge N -> pc_if=target after edge N, instruction in ID after edge N+1.
// CONFIGURATION
// - Macro IF_PERF_CNT_EN.
// - Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
//   - perf_fetch_cnt: +1 each cycle imem_en=1 outside BOOT.
//   - perf_stall_cnt: +1 each cycle in STALL.
//   - Both wrap at 2^32.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset release, enable=1, RESET_PC=0, BOOT_CYCLES=2:
//   - fetch_valid=0 for 2 cycles, then pc_if=0,4,8,...; imem_addr=0,1,2.
// - Stall: enable=0 for 3 cycles at pc_if=0x10 -> pc_if stays 0x10, imem_en=0; resume -> 0x14.
// - Redirect 0x40 while pc_if=0x20, enable=1 -> pc_if=0x40 next cycle, kill_id=1 one cycle, then 0x44.
// - Redirect 0x83 with enable=0 -> pc_if=0x80, imem_en=1, kill_id pulse; redirect beats stall.
// - Wrap, ADDR_SIZE=10: pc_if=0xFFC, enable=1 -> pc_if=0x000.
// - Async reset mid-run at pc_if=0x30 -> pc_if=RESET_PC immediately; with IF_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory, and
// sequences BOOT/RUN/STALL with redirect and wrong-path kill. Optional macro: IF_PERF_CNT_EN.
module if_fetch_stage #(
    parameter int                      DATA_SIZE   = 32,
    parameter int                      ADDR_SIZE   = 10,
    parameter logic [ADDR_SIZE+1:0]    RESET_PC    = '0,
    parameter int                      BOOT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   redirect_valid,
    input  logic [ADDR_SIZE+1:0]   redirect_pc,
    output logic [ADDR_SIZE+1:0]   pc_if,
    output logic [ADDR_SIZE-1:0]   imem_addr,
    output logic                   imem_en,
    output logic                   fetch_valid,
    output logic                   kill_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam int PC_W  = ADDR_SIZE + 2;
    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [PC_W-1:0]     pc_reg, pc_next;
    logic [CNT_W-1:0]    boot_cnt_reg, boot_cnt_next;
    logic                kill_reg, kill_next;
    logic [PC_W-1:0]     redirect_target;

    // Target is forced word-aligned; the byte-offset bits are dropped on purpose.
    logic [1:0] unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[PC_W-1:2], 2'b00};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            boot_cnt_reg <= '0;
            kill_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            boot_cnt_reg <= boot_cnt_next;
            kill_reg     <= kill_next;
        end
    end

    // Next-state logic; redirect takes priority over stall outside BOOT.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        boot_cnt_next = boot_cnt_reg;
        kill_next     = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                boot_cnt_next = boot_cnt_reg + 1'b1;
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_STALL: begin
                if (redirect_valid) begin
                    state_next = ST_RUN;
                    pc_next    = redirect_target;
                    kill_next  = 1'b1;
                end else if (enable) begin
                    state_next = ST_RUN;
                    pc_next    = pc_reg + PC_W'(4);
                end else begin
                    state_next = ST_STALL;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Output logic
    always_comb begin
        imem_en     = 1'b0;
        fetch_valid = 1'b0;
        case (state_reg)
            ST_RUN, ST_STALL: begin
                fetch_valid = 1'b1;
                imem_en     = enable | redirect_valid;
            end
            default: begin
                fetch_valid = 1'b0;
                imem_en     = 1'b0;
            end
        endcase
    end

    assign pc_if     = pc_reg;
    assign imem_addr = pc_reg[PC_W-1:2];
    assign kill_id   = kill_reg;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_reg;
    logic [31:0] perf_stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt_reg <= '0;
            perf_stall_cnt_reg <= '0;
        end else begin
            if (imem_en && (state_reg != ST_BOOT)) begin
                perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
            end
            if (state_reg == ST_STALL) begin
                perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_reg;
    assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: boot, stall, redirect, kill pulses, wrap and async reset.
module tb_if_fetch_stage;

    localparam int ADDR_SIZE = 10;
    localparam int PC_W      = ADDR_SIZE + 2;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic                 redirect_valid;
    logic [PC_W-1:0]      redirect_pc;
    logic [PC_W-1:0]      pc_if;
    logic [ADDR_SIZE-1:0] imem_addr;
    logic                 imem_en;
    logic                 fetch_valid;
    logic                 kill_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0]          perf_fetch_cnt;
    logic [31:0]          perf_stall_cnt;
`endif

    int n_cmp;
    int n_bad;

    if_fetch_stage #(
        .DATA_SIZE   (32),
        .ADDR_SIZE   (ADDR_SIZE),
        .RESET_PC    ('0),
        .BOOT_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_if          (pc_if),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .fetch_valid    (fetch_valid),
        .kill_id        (kill_id)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running wanted finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t pc_if=0x%03h addr=0x%03h en=%0b fv=%0b kill=%0b",
                 $time, pc_if, imem_addr, imem_en, fetch_valid, kill_id);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        #3;
        n_cmp++; if (pc_if !== 12'h000) begin n_bad++; $display("FAIL reset_pc: got 0x%03h wanted 0x000", pc_if); end
        n_cmp++; if (imem_addr !== 10'h000) begin n_bad++; $display("FAIL reset_addr: got 0x%03h wanted 0x000", imem_addr); end
        n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %0b wanted 0", imem_en); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %0b wanted 0", fetch_valid); end
        n_cmp++; if (kill_id !== 1'b0) begin n_bad++; $display("FAIL reset_kill: got %0b wanted 0", kill_id); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL boot0_fv: got %0b wanted 0", fetch_valid); end
        step();
        n_cmp++; if (fetch_valid !== 1'b0 || imem_en !== 1'b0) begin n_bad++; $display("FAIL boot1: got fv=%0b en=%0b wanted 0/0", fetch_valid, imem_en); end
        step();
        n_cmp++; if (fetch_valid !== 1'b1 || pc_if !== 12'h000 || imem_en !== 1'b1) begin n_bad++; $display("FAIL run0: got fv=%0b pc=0x%03h en=%0b wanted 1/0x000/1", fetch_valid, pc_if, imem_en); end
        step();
        n_cmp++; if (pc_if !== 12'h004 || imem_addr !== 10'd1) begin n_bad++; $display("FAIL run1: got pc=0x%03h addr=%0d wanted 0x004/1", pc_if, imem_addr); end
        step();
        n_cmp++; if (pc_if !== 12'h008 || imem_addr !== 10'd2) begin n_bad++; $display("FAIL run2: got pc=0x%03h addr=%0d wanted 0x008/2", pc_if, imem_addr); end
        step();
        step();
        n_cmp++; if (pc_if !== 12'h010) begin n_bad++; $display("FAIL run4: got pc=0x%03h wanted 0x010", pc_if); end
    endtask

    task automatic test_stall();
        enable = 1'b0;
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL stall_c0_en: got %0b wanted 0", imem_en); end
        for (int i = 1; i < 3; i++) begin
            step();
            n_cmp++; if (pc_if !== 12'h010 || imem_en !== 1'b0 || fetch_valid !== 1'b1) begin
                n_bad++; $display("FAIL stall_c%0d: got pc=0x%03h en=%0b fv=%0b wanted 0x010/0/1", i, pc_if, imem_en, fetch_valid);
            end
        end
        enable = 1'b1;
        step();
        n_cmp++; if (pc_if !== 12'h014) begin n_bad++; $display("FAIL stall_resume: got pc=0x%03h wanted 0x014", pc_if); end
        step(); step(); step();
        n_cmp++; if (pc_if !== 12'h020) begin n_bad++; $display("FAIL pre_redirect: got pc=0x%03h wanted 0x020", pc_if); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 12'h040;
        #1;
        n_cmp++; if (imem_en !== 1'b1 || kill_id !== 1'b0) begin n_bad++; $display("FAIL redir_accept: got en=%0b kill=%0b wanted 1/0", imem_en, kill_id); end
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (pc_if !== 12'h040 || kill_id !== 1'b1) begin n_bad++; $display("FAIL redir_target: got pc=0x%03h kill=%0b wanted 0x040/1", pc_if, kill_id); end
        step();
        n_cmp++; if (pc_if !== 12'h044 || kill_id !== 1'b0) begin n_bad++; $display("FAIL redir_after: got pc=0x%03h kill=%0b wanted 0x044/0", pc_if, kill_id); end
    endtask

    task automatic test_redirect_beats_stall();
        enable = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'h083;
        #1;
        n_cmp++; if (imem_en !== 1'b1) begin n_bad++; $display("FAIL rstall_en: got %0b wanted 1", imem_en); end
        step();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (pc_if !== 12'h080 || kill_id !== 1'b1 || imem_en !== 1'b0) begin
            n_bad++; $display("FAIL rstall_target: got pc=0x%03h kill=%0b en=%0b wanted 0x080/1/0", pc_if, kill_id, imem_en);
        end
        step();
        n_cmp++; if (pc_if !== 12'h080 || kill_id !== 1'b0 || fetch_valid !== 1'b1) begin
            n_bad++; $display("FAIL rstall_hold: got pc=0x%03h kill=%0b fv=%0b wanted 0x080/0/1", pc_if, kill_id, fetch_valid);
        end
        enable = 1'b1;
        step();
        n_cmp++; if (pc_if !== 12'h084) begin n_bad++; $display("FAIL rstall_resume: got pc=0x%03h wanted 0x084", pc_if); end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1; redirect_pc = 12'h100;
        step();
        redirect_pc = 12'h200;
        n_cmp++; if (pc_if !== 12'h100 || kill_id !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got pc=0x%03h kill=%0b wanted 0x100/1", pc_if, kill_id); end
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (pc_if !== 12'h200 || kill_id !== 1'b1) begin n_bad++; $display("FAIL b2b_second: got pc=0x%03h kill=%0b wanted 0x200/1", pc_if, kill_id); end
        step();
        n_cmp++; if (pc_if !== 12'h204 || kill_id !== 1'b0) begin n_bad++; $display("FAIL b2b_after: got pc=0x%03h kill=%0b wanted 0x204/0", pc_if, kill_id); end
        // Redirect to the address already in pc_if still reloads and kills.
        redirect_valid = 1'b1; redirect_pc = 12'h204;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (pc_if !== 12'h204 || kill_id !== 1'b1) begin n_bad++; $display("FAIL same_target: got pc=0x%03h kill=%0b wanted 0x204/1", pc_if, kill_id); end
        step();
        n_cmp++; if (pc_if !== 12'h208 || kill_id !== 1'b0) begin n_bad++; $display("FAIL same_after: got pc=0x%03h kill=%0b wanted 0x208/0", pc_if, kill_id); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 12'hFFC;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (pc_if !== 12'hFFC || imem_addr !== 10'h3FF) begin n_bad++; $display("FAIL wrap_top: got pc=0x%03h addr=0x%03h wanted 0xFFC/0x3FF", pc_if, imem_addr); end
        step();
        n_cmp++; if (pc_if !== 12'h000 || imem_addr !== 10'h000) begin n_bad++; $display("FAIL wrap_zero: got pc=0x%03h addr=0x%03h wanted 0x000/0x000", pc_if, imem_addr); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 12; i++) step();
        n_cmp++; if (pc_if !== 12'h030) begin n_bad++; $display("FAIL arst_pre: got pc=0x%03h wanted 0x030", pc_if); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pc_if !== 12'h000 || fetch_valid !== 1'b0 || imem_en !== 1'b0) begin
            n_bad++; $display("FAIL arst_now: got pc=0x%03h fv=%0b en=%0b wanted 0x000/0/0", pc_if, fetch_valid, imem_en);
        end
`ifdef IF_PERF_CNT_EN
        n_cmp++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            n_bad++; $display("FAIL arst_perf: got fetch=%0d stall=%0d wanted 0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 12'h040;
        step();
        n_cmp++; if (pc_if !== 12'h000 || kill_id !== 1'b0 || fetch_valid !== 1'b0) begin
            n_bad++; $display("FAIL boot_ignore_redir: got pc=0x%03h kill=%0b fv=%0b wanted 0x000/0/0", pc_if, kill_id, fetch_valid);
        end
        redirect_valid = 1'b0;
        step();
        n_cmp++; if (pc_if !== 12'h000 || fetch_valid !== 1'b1) begin n_bad++; $display("FAIL reboot_run: got pc=0x%03h fv=%0b wanted 0x000/1", pc_if, fetch_valid); end
        step();
        n_cmp++; if (pc_if !== 12'h004) begin n_bad++; $display("FAIL reboot_adv: got pc=0x%03h wanted 0x004", pc_if); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_beats_stall();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
